// File: rtl/scan_disp_pkg.sv
// scan_disp_pkg: shared display defaults, polarity constants and width helper
package scan_disp_pkg;
  localparam int DW_DEF = 4;
  localparam int DIGITS_DEF = 8;
  localparam logic SEL_OFF = 1'b1;
  localparam logic DP_OFF = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/scan_disp_if.sv
// scan_disp_if: digit data in, multiplexed display drive out
interface scan_disp_if import scan_disp_pkg::*; #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DW = DW_DEF
);
  localparam int SW = clog2(DIGITS);
  logic en, load, lzb;
  logic [DIGITS*DW-1:0] d;
  logic [DIGITS-1:0] dpmask;
  logic [DW-1:0] y;
  logic dp;
  logic [DIGITS-1:0] sel;
  logic [SW-1:0] s;
  logic frame, pend;
  modport master (output en, d, dpmask, load, lzb, input y, dp, sel, s, frame, pend);
  modport slave (input en, d, dpmask, load, lzb, output y, dp, sel, s, frame, pend);
endinterface

// File: rtl/scan_tick.sv
// scan_tick: prescaler producing the slot tick and the scan index
module scan_tick import scan_disp_pkg::*; #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DIV = 4,
  localparam int SW = clog2(DIGITS),
  localparam int CW = clog2(DIV)
) (
  input logic clk,
  input logic rst,
  input logic en,
  output logic tick,
  output logic [SW-1:0] s
);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      s <= '0;
    end else if (tick) begin
      cnt <= '0;
      s <= s == SW'(DIGITS - 1) ? '0 : s + SW'(1);
    end else if (en)
      cnt <= cnt + CW'(1);
endmodule

// File: rtl/scan_disp.sv
// scan_disp: multiplexed digit scanner with frame-synchronous double buffering
module scan_disp import scan_disp_pkg::*; #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DW = DW_DEF,
  parameter int DIV = 4,
  localparam int SW = clog2(DIGITS)
) (
  input logic clk,
  input logic rst,
  scan_disp_if.slave bus
);
  logic tick, wrap, blank;
  logic [SW-1:0] s;
  logic [DIGITS*DW-1:0] pend_d, shad_d;
  logic [DIGITS-1:0] pend_m, shad_m, onehot;
  scan_tick #(.DIGITS(DIGITS), .DIV(DIV)) u_tick (.clk(clk), .rst(rst), .en(bus.en), .tick(tick), .s(s));
  assign wrap = tick && s == SW'(DIGITS - 1);
  assign blank = bus.lzb && s != '0 && (shad_d >> (s * DW)) == '0;
  assign onehot = DIGITS'(1) << s;
  assign bus.s = s;
  always_ff @(posedge clk)
    if (rst) begin
      pend_d <= '0;
      pend_m <= '0;
      shad_d <= '0;
      shad_m <= '0;
      bus.pend <= 1'b0;
      bus.frame <= 1'b0;
      bus.y <= '0;
      bus.dp <= DP_OFF;
      bus.sel <= {DIGITS{SEL_OFF}};
    end else begin
      bus.frame <= wrap;
      bus.pend <= bus.load || (bus.pend && !wrap);
      if (bus.load) begin
        pend_d <= bus.d;
        pend_m <= bus.dpmask;
      end
      if (wrap && bus.pend) begin
        shad_d <= pend_d;
        shad_m <= pend_m;
      end
      if (bus.en) begin
        bus.y <= shad_d[s*DW +: DW];
        bus.dp <= (blank || !shad_m[s]) ? DP_OFF : ~DP_OFF;
        bus.sel <= blank ? {DIGITS{SEL_OFF}} : {DIGITS{SEL_OFF}} ^ onehot;
      end
    end
endmodule

// File: doc/scan_disp.md
SCAN_DISP -- requirements
Module: scan_disp

Interface
REQ-001 Parameter DIGITS, default 8, number of scanned digits (2..16).
REQ-002 Parameter DW, default 4, bits per digit code.
REQ-003 Parameter DIV, default 4, CLK cycles per digit slot (>=1).
REQ-004 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 EN  in  1  scan enable; 0 freezes prescaler, index and all outputs.
REQ-007 D  in  DIGITS*DW  digit codes; digit i is D[i*DW +: DW], digit 0 least significant.
REQ-008 DPMASK  in  DIGITS  decimal-point request per digit, 1 = point lit.
REQ-009 LOAD  in  1  single-cycle strobe capturing D and DPMASK into the pending buffer.
REQ-010 LZB  in  1  leading-zero blanking mode.
REQ-011 Y  out  DW  code of the currently driven digit.
REQ-012 DP  out  1  decimal point, active-low (0 = lit).
REQ-013 SEL  out  DIGITS  digit enable, active-low one-hot; all ones = display dark.
REQ-014 S  out  clog2(DIGITS)  current scan index.
REQ-015 FRAME  out  1  one-cycle pulse marking the start of a new frame.
REQ-016 PEND  out  1  pending buffer holds data not yet displayed.

Function
REQ-017 Prescaler counts 0..DIV-1 while EN=1; tick is asserted when the count is DIV-1 and EN=1; the count wraps to 0 on tick.
REQ-018 On tick, S increments; S=DIGITS-1 wraps to 0 (frame boundary).
REQ-019 FRAME is registered and equals 1 exactly in the cycle S first holds 0 after a wrap; otherwise 0.
REQ-020 LOAD copies D and DPMASK into the pending buffer and sets PEND the next cycle; the displayed shadow is not altered.
REQ-021 At the frame-boundary tick with PEND=1, shadow loads from pending and PEND clears, so no frame shows mixed old and new data.
REQ-022 LOAD coincident with the boundary tick: the old pending contents transfer to shadow, the new values overwrite pending, and PEND stays 1.
REQ-023 Repeated LOADs before a boundary: the last one wins.
REQ-024 Y, DP and SEL are registered, reflecting the new S one cycle after S changes (latency 1).
REQ-025 Y = shadow digit S; DP = NOT shadow DPMASK[S]; SEL[S]=0, other SEL bits 1.
REQ-026 LZB=1: a digit k>0 is blank when shadow digits k..DIGITS-1 are all zero; a blank slot drives SEL all ones and DP=1; digit 0 is never blanked.
REQ-027 EN=0 holds the prescaler, S, shadow and all outputs; LOAD is still accepted and PEND still updates.
REQ-028 DIV=1: tick is asserted every enabled cycle.

Reset
REQ-029 RST=1 on an edge sets prescaler=0, S=0, shadow=0, pending=0, PEND=0, Y=0, DP=1, SEL all ones, FRAME=0; RST overrides LOAD and EN.
REQ-030 Reset mid-frame discards pending and shadow data; the first cycle after RST deasserts, SEL=~1 and Y=0 are driven (with EN=1).

Structure
REQ-031 The shared display package holds DW default, DIGITS default, the clog2 helper and the active-low polarity constants for SEL and DP.
REQ-032 The prescaler/index counter is one sub-module, scan_tick, producing tick and S.

Verification
REQ-033 DIGITS=4, DIV=2, EN=1 after reset -> S sequence 0,0,1,1,2,2,3,3,0; FRAME high once per 8 cycles at S returning to 0; SEL cycles E,D,B,7 (hex) with 1-cycle lag.
REQ-034 LOAD D=0x4321, DPMASK=0b0100 mid-frame -> PEND=1; the display keeps the old data until the boundary, then Y runs 1,2,3,4; DP=0 only when S=2; PEND=0.
REQ-035 LZB=1, shadow 0x0050 -> slots 3 and 2 give SEL=F, DP=1; slot 1 gives Y=5; slot 0 gives Y=0 with SEL=E.
REQ-036 LOAD 0x1111 then LOAD 0x2222 in the boundary-tick cycle -> the frame shows 1111, the following frame 2222, and PEND stays high between them.
REQ-037 EN=0 for 5 cycles mid-frame -> S, Y and SEL frozen; a LOAD during the freeze sets PEND; the scan resumes from the same prescaler count.
REQ-038 RST asserted at S=2 with PEND=1 -> next cycle S=0, PEND=0, Y=0, DP=1, SEL=F.
